// File: rtl/register_unit_if.sv
// Bus bundle for the register unit: control/data inputs from the processor
// and the registered status/data outputs back to it.
interface register_unit_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 2);

  logic             load_a;
  logic             load_b;
  logic [WIDTH-1:0] din;
  logic [2:0]       fn;
  logic [1:0]       route;
  logic             shift_enable;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [CW-1:0]    shift_count;
  logic             op_done;
  logic             burst_error;

  // Control side (processor / testbench).
  modport master (
    output load_a, load_b, din, fn, route, shift_enable,
    input  a_out, b_out, shift_count, op_done, burst_error
  );

  // Register unit side.
  modport slave (
    input  load_a, load_b, din, fn, route, shift_enable,
    output a_out, b_out, shift_count, op_done, burst_error
  );
endinterface

// File: rtl/register_unit.sv
// Register unit: operand registers A/B that serially apply a bitwise logic
// function one bit per shift_enable cycle, plus a burst-length tracker that
// flags bursts not exactly WIDTH cycles long.
module register_unit #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  register_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_OVER = CW'(WIDTH + 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] SHIFTING = 1'b1;

  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    count_q;
  logic [0:0]       state_q;
  logic             op_done_q;
  logic             error_q;

  logic f_bit;
  logic a_in, b_in;

  // Select the logic function of the two LSBs.
  always_comb begin
    // NOTE: default first so every path assigns f_bit; otherwise a latch is inferred.
    f_bit = 1'b0;
    case (bus.fn)
      3'b000: f_bit = a_q[0] & b_q[0];
      3'b001: f_bit = a_q[0] | b_q[0];
      3'b010: f_bit = a_q[0] ^ b_q[0];
      3'b011: f_bit = 1'b1;
      3'b100: f_bit = ~(a_q[0] & b_q[0]);
      3'b101: f_bit = ~(a_q[0] | b_q[0]);
      3'b110: f_bit = ~(a_q[0] ^ b_q[0]);
      default: f_bit = 1'b0;
    endcase
  end

  // Route the function result and the LSBs to the serial inputs of A and B.
  always_comb begin
    a_in = a_q[0];
    b_in = b_q[0];
    case (bus.route)
      2'b00: begin a_in = a_q[0]; b_in = b_q[0]; end
      2'b01: begin a_in = a_q[0]; b_in = f_bit;  end
      2'b10: begin a_in = f_bit;  b_in = b_q[0]; end
      default: begin a_in = b_q[0]; b_in = a_q[0]; end
    endcase
  end

  // Operand registers: shift while enabled, otherwise accept parallel loads.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (bus.shift_enable) begin
      a_q <= {a_in, a_q[WIDTH-1:1]};
      b_q <= {b_in, b_q[WIDTH-1:1]};
    end else begin
      if (bus.load_a) a_q <= bus.din;
      if (bus.load_b) b_q <= bus.din;
    end
  end

  // Burst tracker: count shifts, pulse op_done on an exact burst, flag others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_done_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      op_done_q <= 1'b0;

      // A load clears the sticky error; a fault detected this same cycle
      // is assigned later in the block and therefore takes precedence.
      if (!bus.shift_enable && (bus.load_a || bus.load_b))
        error_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.shift_enable) begin
            state_q <= SHIFTING;
            count_q <= CW'(1);
          end
        end
        default: begin
          if (bus.shift_enable) begin
            if (count_q != COUNT_OVER) begin
              count_q <= count_q + CW'(1);
              if (count_q == COUNT_FULL)
                error_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            if (count_q == COUNT_FULL)
              op_done_q <= 1'b1;
            else if (count_q < COUNT_FULL)
              error_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.a_out       = a_q;
  assign bus.b_out       = b_q;
  assign bus.shift_count = count_q;
  assign bus.op_done     = op_done_q;
  assign bus.burst_error = error_q;
endmodule

// File: tb/tb_register_unit.sv
// Directed testbench for register_unit: hand-computed vectors for each
// routing/function case plus underrun, overrun, load-during-burst and
// mid-burst reset behaviour.
module tb_register_unit;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   done_pulses = 0;
  int   p0;

  register_unit_if #(.WIDTH(WIDTH)) bus ();

  register_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Count op_done pulses as seen at each rising edge.
  always @(posedge clk) if (bus.op_done === 1'b1) done_pulses++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load_ab(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.din = a; bus.load_a = 1'b1;
    step();
    bus.load_a = 1'b0; bus.din = b; bus.load_b = 1'b1;
    step();
    bus.load_b = 1'b0; bus.din = '0;
  endtask

  task automatic burst(input int n);
    bus.shift_enable = 1'b1;
    step(n);
    bus.shift_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.load_a = 1'b0; bus.load_b = 1'b0; bus.din = '0;
    bus.fn = 3'b000; bus.route = 2'b00; bus.shift_enable = 1'b0;
    @(negedge clk);
    step(2);
    reset = 1'b0;
    check("rst_a", bus.a_out, 4'h0);
    check("rst_b", bus.b_out, 4'h0);
    check("rst_cnt", bus.shift_count, 3'd0);
    check("rst_done", bus.op_done, 1'b0);
    check("rst_err", bus.burst_error, 1'b0);

    // AND into A: 1010 & 1100 = 1000.
    load_ab(4'b1010, 4'b1100);
    bus.fn = 3'b000; bus.route = 2'b10;
    p0 = done_pulses;
    burst(4);
    check("and_cnt", bus.shift_count, 3'd4);
    check("and_done_early", bus.op_done, 1'b0);
    step();
    check("and_done", bus.op_done, 1'b1);
    check("and_a", bus.a_out, 4'b1000);
    check("and_b", bus.b_out, 4'b1100);
    check("and_err", bus.burst_error, 1'b0);
    step();
    check("and_done_low", bus.op_done, 1'b0);
    check("and_cnt_hold", bus.shift_count, 3'd4);
    check("and_pulses", done_pulses - p0, 1);

    // Swap.
    load_ab(4'b0011, 4'b0101);
    bus.route = 2'b11;
    p0 = done_pulses;
    burst(4);
    step();
    check("swap_done", bus.op_done, 1'b1);
    check("swap_a", bus.a_out, 4'b0101);
    check("swap_b", bus.b_out, 4'b0011);
    step();
    check("swap_pulses", done_pulses - p0, 1);

    // XOR into B: 1010 ^ 0110 = 1100; then constant 1 into A.
    load_ab(4'b1010, 4'b0110);
    bus.fn = 3'b010; bus.route = 2'b01;
    burst(4);
    step();
    check("xor_a", bus.a_out, 4'b1010);
    check("xor_b", bus.b_out, 4'b1100);
    bus.fn = 3'b011; bus.route = 2'b10;
    burst(4);
    step();
    check("one_a", bus.a_out, 4'b1111);
    check("one_b", bus.b_out, 4'b1100);

    // Route 00 rotates both registers back to their original value.
    load_ab(4'b1001, 4'b0110);
    bus.fn = 3'b101; bus.route = 2'b00;
    burst(4);
    step();
    check("rot_a", bus.a_out, 4'b1001);
    check("rot_b", bus.b_out, 4'b0110);
    step();

    // Underrun: 2-cycle burst.
    p0 = done_pulses;
    burst(2);
    check("under_cnt_mid", bus.shift_count, 3'd2);
    check("under_err_mid", bus.burst_error, 1'b0);
    step();
    check("under_err", bus.burst_error, 1'b1);
    check("under_done", bus.op_done, 1'b0);
    check("under_cnt", bus.shift_count, 3'd2);
    step();
    check("under_err_sticky", bus.burst_error, 1'b1);
    bus.load_a = 1'b1; bus.din = 4'b0000;
    step();
    bus.load_a = 1'b0;
    check("under_err_clear", bus.burst_error, 1'b0);
    check("under_pulses", done_pulses - p0, 0);

    // Overrun: 6-cycle burst.
    bus.fn = 3'b000; bus.route = 2'b00;
    p0 = done_pulses;
    bus.shift_enable = 1'b1;
    step(4);
    check("over_cnt4", bus.shift_count, 3'd4);
    check("over_err4", bus.burst_error, 1'b0);
    step();
    check("over_cnt5", bus.shift_count, 3'd5);
    check("over_err5", bus.burst_error, 1'b1);
    step();
    check("over_cnt_sat", bus.shift_count, 3'd5);
    bus.shift_enable = 1'b0;
    step();
    check("over_done", bus.op_done, 1'b0);
    check("over_err_end", bus.burst_error, 1'b1);
    step();
    check("over_pulses", done_pulses - p0, 0);

    // Load during burst is ignored.
    load_ab(4'b1010, 4'b1100);
    bus.fn = 3'b000; bus.route = 2'b10;
    bus.shift_enable = 1'b1;
    step();
    bus.load_a = 1'b1; bus.din = 4'b1111;
    step();
    bus.load_a = 1'b0; bus.din = '0;
    step(2);
    bus.shift_enable = 1'b0;
    step();
    check("ldig_done", bus.op_done, 1'b1);
    check("ldig_a", bus.a_out, 4'b1000);
    check("ldig_b", bus.b_out, 4'b1100);
    step();

    // Reset after two shifts abandons the burst.
    load_ab(4'b1010, 4'b1100);
    burst(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_a", bus.a_out, 4'h0);
    check("mrst_b", bus.b_out, 4'h0);
    check("mrst_cnt", bus.shift_count, 3'd0);
    check("mrst_err", bus.burst_error, 1'b0);
    check("mrst_done", bus.op_done, 1'b0);
    p0 = done_pulses;
    step(3);
    check("mrst_err_after", bus.burst_error, 1'b0);
    check("mrst_done_after", bus.op_done, 1'b0);
    check("mrst_pulses", done_pulses - p0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- Datapath end of the logic processor's shift interface. Consumes the `shift_enable` burst produced by the processor's control unit.
- Holds operand registers A and B. On each enabled cycle, computes one bit of a bitwise logic function on their LSBs and shifts the routed results in at the MSB.
- Checks that every burst is exactly WIDTH cycles long. Reports a completion pulse or a protocol error to the rest of the processor.

Parameters:
- WIDTH, 4, register width; also the required `shift_enable` burst length in cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- load_a  input  1  load `din` into A (ignored while `shift_enable`=1)
- load_b  input  1  load `din` into B (ignored while `shift_enable`=1)
- din  input  WIDTH  parallel load data (switches)
- fn  input  3  logic function select
- route  input  2  result routing select
- shift_enable  input  1  one serial step per cycle high
- a_out  output  WIDTH  current A register
- b_out  output  WIDTH  current B register
- shift_count  output  $clog2(WIDTH+2)  shifts taken in current/most recent burst
- op_done  output  1  one-cycle pulse: burst of exactly WIDTH completed
- burst_error  output  1  sticky flag: burst length was not WIDTH

Behaviour:
- Reset (synchronous, active-high, priority over every other input): A=0, B=0, `shift_count`=0, `op_done`=0, `burst_error`=0, state=IDLE. A reset mid-burst abandons the burst with no `op_done` and no error.
- Function bit F is computed from A[0] and B[0], selected by `fn`:
  - 000 AND, 001 OR, 010 XOR, 011 constant 1
  - 100 NAND, 101 NOR, 110 XNOR, 111 constant 0
- Route selects the incoming bits (a_in, b_in):
  - 00: (A[0], B[0]), both registers rotate.
  - 01: (A[0], F).
  - 10: (F, B[0]).
  - 11: (B[0], A[0]), swap.
- Shift cycle (`shift_enable`=1): A <= {a_in, A[WIDTH-1:1]}; B <= {b_in, B[WIDTH-1:1]}. After exactly WIDTH shifts the destination holds the full bitwise result, and route 00 leaves A and B unchanged.
- Load (`shift_enable`=0): `load_a` gives A <= din; `load_b` gives B <= din. Both may load in the same cycle.
  - Load while `shift_enable`=1: the load is ignored and the shift proceeds.
  - A load also clears `burst_error`.
- Burst tracker FSM, states IDLE and SHIFTING:
  - IDLE & `shift_enable`: go to SHIFTING; `shift_count` <= 1.
  - SHIFTING & `shift_enable`: `shift_count` increments, saturating at WIDTH+1.
  - On the increment that reaches WIDTH+1 (overrun), `burst_error` <= 1.
  - SHIFTING & !`shift_enable`: go to IDLE.
    - If `shift_count`==WIDTH: `op_done` <= 1 for exactly one cycle.
    - Else if `shift_count` < WIDTH (underrun): `burst_error` <= 1, no `op_done`.
  - An overrun burst yields no `op_done` when it ends.
  - `shift_count` holds its value in IDLE until the next burst starts.
- Latency:
  - `op_done` is high in the cycle after the first low sample of `shift_enable`, i.e. the cycle after the IDLE transition registers.
  - For a standard control-unit burst (`shift_enable` high 4 cycles starting at edge 0), `op_done` is high during cycle 5.
- `burst_error` stays set until reset or a load.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Load A=1010, B=1100; fn=000, route=10; 4-cycle burst -> A=1000, B=1100, `shift_count`=4, one `op_done` pulse, `burst_error`=0.
- Load A=0011, B=0101; route=11; 4-cycle burst -> A=0101, B=0011, `op_done` pulses once.
- Load A=1010, B=0110; fn=010, route=01; 4-cycle burst -> A=1010, B=1100. Repeat with fn=011, route=10 -> A=1111.
- 2-cycle burst -> `shift_count`=2, `burst_error`=1, no `op_done`. A subsequent `load_a` clears `burst_error`.
- 6-cycle burst -> `burst_error`=1 on the 5th shift edge, `shift_count` saturates at 5, no `op_done`.
- `load_a` with din=1111 asserted during burst cycle 2 -> load ignored, A result identical to the burst without the load.
- Reset asserted after 2 shifts of a burst -> A=B=0, `shift_count`=0, flags 0; no `op_done` or error afterwards.
